ram: RTL and testbench
======================

// Module: ram
//
// PURPOSE
//   Single-port, word-addressed random-access memory: one shared address bus,
//   separate write-data and read-data buses, chip select and write enable.
//   Writes are synchronous to clk. Reads are asynchronous (combinational).
//   Used as general scratch/data storage inside larger datapaths.
//   Contents are held in a flop array so that reset can clear every word.
//
// PARAMETERS
//   addr_size    10     address width in bits
//   word_size    8      data word width in bits
//   memory_size  1024   number of words; must be <= 2**addr_size
//
// PORTS
//   clk       in   1           clock; all writes occur on its rising edge
//   rst       in   1           reset, asynchronous, active-high
//   data_out  out  word_size   read data
//   data_in   in   word_size   write data
//   addr      in   addr_size   word address for both read and write
//   wr        in   1           1 = write, 0 = read (qualified by cs)
//   cs        in   1           chip select, active-high; 0 = block idle
//
// BEHAVIOUR
//   - Reset (rst=1, asynchronous, no clock required):
//     every word is cleared to 0. data_out reads 0 while rst=1.
//     Writes are blocked while rst=1; reset has priority over a same-edge write.
//   - Write: on posedge clk with cs=1, wr=1, addr<memory_size:
//     mem[addr] <= data_in. The new value is visible combinationally after that edge.
//   - Read: combinational. data_out = mem[addr] whenever cs=1, wr=0, rst=0
//     and addr<memory_size. No clock latency: data_out follows addr changes
//     within the same cycle.
//   - data_out = 0 when cs=0, when wr=1 (no write-through), or when rst=1.
//   - Out of range (addr >= memory_size, possible only if memory_size < 2**addr_size):
//     a write is ignored with no aliasing or wrap-around; a read returns 0.
//   - cs=0: no write on any edge, regardless of wr, addr or data_in.
//   - Back-to-back writes to different addresses on consecutive edges each
//     complete independently.
//   - Repeated writes to the same address: the last write wins.
//   - Address 0 and address memory_size-1 are fully usable.
//   - No X propagation after reset: every word is defined.
//
// TESTING
//   1. Assert rst, then release; read addr 0, 10 and 1023 with cs=1, wr=0
//      -> data_out = 8'h00 at each address.
//   2. cs=1, wr=1: write addr 10 = 8'hAB, then addr 20 = 8'hCD on consecutive edges.
//      Then wr=0: addr 10 -> 8'hAB, addr 20 -> 8'hCD, each combinational with
//      no clock edge needed.
//   3. cs=0, wr=1, addr=30, data_in=8'h55 across several edges; then cs=1, wr=0
//      -> addr 30 reads 8'h00; data_out = 0 throughout cs=0.
//   4. Write addr 1023 = 8'hFF, write addr 0 = 8'h01, write addr 10 = 8'h12
//      over AB -> reads return FF, 01 and 12 respectively.
//   5. Assert rst asynchronously, mid-cycle, after tests 2 and 4
//      -> data_out = 0 immediately; after release, addr 10, 20 and 1023 read 00.
//   6. While wr=1 with cs=1 -> data_out = 0. Read addr 10 while it is being
//      written -> data_out = 0 during wr=1, new value once wr=0.

Source files
------------

// File: rtl/ram.sv
// Single-port word-addressed RAM built from flops so an asynchronous reset can clear
// every word. Writes land on the rising clock edge; reads are purely combinational.
module ram #(
  parameter int addr_size   = 10,
  parameter int word_size   = 8,
  parameter int memory_size = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [word_size-1:0] data_out,
  input  logic [word_size-1:0] data_in,
  input  logic [addr_size-1:0] addr,
  input  logic                 wr,
  input  logic                 cs
);

  // One extra bit so memory_size == 2**addr_size is representable.
  localparam logic [addr_size:0] MemSize = (addr_size + 1)'(memory_size);

  logic                 in_range;
  logic                 wr_en;
  logic [word_size-1:0] rd_words [memory_size];

  assign in_range = ({1'b0, addr} < MemSize);
  assign wr_en    = cs & wr & in_range;

  // Each word owns its own register so reset clears the whole array at once.
  for (genvar gi = 0; gi < memory_size; gi++) begin : g_word
    logic                 hit;
    logic [word_size-1:0] word_q;

    assign hit = wr_en && (addr == addr_size'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_q <= '0;
      end else if (hit) begin
        word_q <= data_in;
      end
    end

    assign rd_words[gi] = word_q;
  end

  // No write-through: the bus reads zero whenever it is not a qualified, in-range read.
  always_comb begin
    data_out = '0;
    if (!rst && cs && !wr && in_range) begin
      data_out = rd_words[addr];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed vector table, hand-written reset and
// combinational-read sequences, then random traffic against an array model.
module tb_ram;

  logic       clk;
  logic       rst;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic [9:0] addr;
  logic       wr;
  logic       cs;

  int n_checks;
  int n_fail;

  logic [7:0] model [1024];

  typedef struct {
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [$];

  ram #(
    .addr_size  (10),
    .word_size  (8),
    .memory_size(1024)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_out(data_out),
    .data_in (data_in),
    .addr    (addr),
    .wr      (wr),
    .cs      (cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: data_out=%h", name, act);
    end
  endtask

  // Drive a bus cycle in the low phase, check the combinational output, then let the edge pass.
  task automatic apply(input logic c, input logic w, input logic [9:0] a,
                       input logic [7:0] d, input logic [7:0] exp, input string name);
    @(negedge clk);
    cs      = c;
    wr      = w;
    addr    = a;
    data_in = d;
    #1;
    check(name, data_out, exp);
  endtask

  task automatic add(input logic c, input logic w, input logic [9:0] a,
                     input logic [7:0] d, input logic [7:0] exp, input string name);
    vec_t v;
    v.cs = c; v.wr = w; v.addr = a; v.din = d; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [9:0] ra;
    logic [7:0] rd;
    int         op;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    cs       = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    data_in  = '0;

    // Reset phase: writes attempted during reset must be blocked.
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 10'd5; data_in = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wr = 1'b0; #1;
    check("reset_hold_read5", data_out, 8'h00);
    rst = 1'b0;
    #1;
    check("after_reset_addr5_blocked", data_out, 8'h00);

    add(1, 0, 10'd0,    8'h00, 8'h00, "reset_rd0");
    add(1, 0, 10'd10,   8'h00, 8'h00, "reset_rd10");
    add(1, 0, 10'd1023, 8'h00, 8'h00, "reset_rd1023");
    add(1, 1, 10'd10,   8'hAB, 8'h00, "wr10_AB_out0");
    add(1, 1, 10'd20,   8'hCD, 8'h00, "wr20_CD_out0");
    add(1, 0, 10'd10,   8'h00, 8'hAB, "rd10_AB");
    add(1, 0, 10'd20,   8'h00, 8'hCD, "rd20_CD");
    add(0, 1, 10'd30,   8'h55, 8'h00, "cs0_wr30_a");
    add(0, 1, 10'd30,   8'h55, 8'h00, "cs0_wr30_b");
    add(0, 0, 10'd10,   8'h55, 8'h00, "cs0_rd10");
    add(1, 0, 10'd30,   8'h00, 8'h00, "rd30_unwritten");
    add(1, 1, 10'd1023, 8'hFF, 8'h00, "wr1023_FF");
    add(1, 1, 10'd0,    8'h01, 8'h00, "wr0_01");
    add(1, 1, 10'd10,   8'h12, 8'h00, "wr10_12_during_wr");
    add(1, 0, 10'd1023, 8'h00, 8'hFF, "rd1023_FF");
    add(1, 0, 10'd0,    8'h00, 8'h01, "rd0_01");
    add(1, 0, 10'd10,   8'h00, 8'h12, "rd10_12");
    add(1, 1, 10'd20,   8'h3C, 8'h00, "wr20_3C");
    add(1, 1, 10'd20,   8'h4D, 8'h00, "wr20_4D");
    add(1, 0, 10'd20,   8'h00, 8'h4D, "rd20_last_wins");

    foreach (vecs[i]) apply(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);

    // Read follows address changes within one low phase, no edge in between.
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = 10'd0; #1;
    check("comb_rd0", data_out, 8'h01);
    addr = 10'd1023; #1;
    check("comb_rd1023", data_out, 8'hFF);
    addr = 10'd10; #1;
    check("comb_rd10", data_out, 8'h12);
    wr = 1'b1; #1;
    check("comb_wr_blocks_out", data_out, 8'h00);
    wr = 1'b0; #1;
    check("comb_wr_released", data_out, 8'h12);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", data_out, 8'h00);
    #1;
    rst = 1'b0;
    #1;
    check("after_rst_rd10", data_out, 8'h00);
    addr = 10'd20; #1;
    check("after_rst_rd20", data_out, 8'h00);
    addr = 10'd1023; #1;
    check("after_rst_rd1023", data_out, 8'h00);

    // Randomised traffic against a plain array model.
    foreach (model[i]) model[i] = 8'h00;
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 9));
      ra = (n % 7 == 0) ? ((n % 2 == 0) ? 10'd0 : 10'd1023) : 10'($urandom_range(0, 63));
      rd = 8'($urandom);
      if (op < 4) begin
        apply(1, 1, ra, rd, 8'h00, "rand_wr");
        model[ra] = rd;
      end else if (op < 8) begin
        apply(1, 0, ra, rd, model[ra], "rand_rd");
      end else begin
        apply(0, op[0], ra, rd, 8'h00, "rand_idle");
      end
    end
    for (int a = 0; a < 64; a++) apply(1, 0, 10'(a), 8'h00, model[a], "sweep_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
